// File: rtl/fetch_pkg.sv
// Shared constants and the queue entry layout for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned XLEN_DEF    = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue: circular buffer with push/pop and a single-cycle flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  entry_t                       push_data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output entry_t                       head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + PW'(1);
            if (pop_i)  rptr_d = rptr_q + PW'(1);
            unique case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: contents are only observable while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// capture into a queue, and redirect handling that discards in-flight responses.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       XLEN     = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [XLEN-1:0]   imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [XLEN-1:0]   instr_data,
    output logic [XLEN-1:0]   instr_pc
);

    localparam int unsigned     CW      = $clog2(DEPTH+1);
    localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] PC_INIT = {RESET_PC[XLEN-1:2], 2'b00};
    localparam logic [XLEN-1:0] STEP    = XLEN'(INSTR_BYTES);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   q_count;
    entry_t          head;
    entry_t          push_entry;
    logic            push, pop, flush;
    logic            req_hs, rsp_ok;
    logic [XLEN-1:0] redirect_aligned;
    logic            unused_redirect_low;

    assign redirect_aligned    = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_low = ^redirect_pc[1:0];

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok = imem_rsp_valid && (out_q != '0);

    assign imem_req_valid = rst_n && !redirect_valid
                            && (({1'b0, q_count} + {1'b0, out_q}) < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign req_hs         = imem_req_valid && imem_req_ready;

    assign instr_valid = (q_count != '0);
    assign instr_data  = instr_valid ? head.instr : '0;
    assign instr_pc    = instr_valid ? head.pc    : '0;
    assign pop         = instr_valid && instr_ready && !redirect_valid;
    assign push_entry  = '{pc: rsp_pc_q, instr: imem_rsp_data};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_d     = drop_q;
        push       = 1'b0;
        flush      = 1'b0;
        out_d      = out_q + CW'(req_hs) - CW'(rsp_ok);
        if (redirect_valid) begin
            // Everything still in flight belongs to the old path, including drops already owed.
            flush      = 1'b1;
            fetch_pc_d = redirect_aligned;
            rsp_pc_d   = redirect_aligned;
            drop_d     = out_q - CW'(rsp_ok);
        end else begin
            if (req_hs) fetch_pc_d = fetch_pc_q + STEP;
            if (rsp_ok) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    push     = 1'b1;
                    rsp_pc_d = rsp_pc_q + STEP;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= PC_INIT;
            rsp_pc_q   <= PC_INIT;
            out_q      <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (flush),
        .head_o      (head),
        .count_o     (q_count)
    );

    assert property (@(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> (out_q != '0));

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, address/instruction width in bits.
REQ-002 Parameter DEPTH, default 4, instruction queue entries; power of two, >=2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 imem_req_valid  output  1  fetch request presented.
REQ-007 imem_req_ready  input  1  memory accepts request this cycle.
REQ-008 imem_req_addr  output  XLEN  word-aligned fetch address.
REQ-009 imem_rsp_valid  input  1  read data returned, in request order, no backpressure.
REQ-010 imem_rsp_data  input  XLEN  instruction word.
REQ-011 redirect_valid  input  1  branch/jump taken; single-cycle pulse.
REQ-012 redirect_pc  input  XLEN  new fetch target.
REQ-013 instr_valid  output  1  queue head valid.
REQ-014 instr_ready  input  1  decode consumes head.
REQ-015 instr_data  output  XLEN  queue head instruction.
REQ-016 instr_pc  output  XLEN  address of queue head instruction.

Function
REQ-017 Request handshake = imem_req_valid & imem_req_ready; on handshake fetch_pc <= fetch_pc + 4, modulo 2^XLEN (wrap, no flag).
REQ-018 imem_req_valid SHALL be 1 iff !redirect_valid and (queue_count + outstanding) < DEPTH; credit rule guarantees queue never overflows.
REQ-019 imem_req_addr SHALL equal fetch_pc; fetch_pc[1:0] always 0.
REQ-020 outstanding SHALL increment on request handshake, decrement on imem_rsp_valid, both same cycle -> unchanged; width clog2(DEPTH+1).
REQ-021 Response with drop_count > 0: discarded, drop_count decrements; else entry {rsp_pc, imem_rsp_data} pushed, rsp_pc <= rsp_pc + 4.
REQ-022 Push-to-output latency: response in cycle N -> instr_valid in cycle N+1; no bypass.
REQ-023 instr_valid = (queue_count != 0); instr_data/instr_pc from head; pop on instr_valid & instr_ready; simultaneous push and pop keeps count.
REQ-024 Redirect cycle: queue flushed (count -> 0), fetch_pc and rsp_pc <= {redirect_pc[XLEN-1:2], 2'b00}, no request issued, any pop ignored.
REQ-025 Redirect cycle: drop_count <= outstanding - (imem_rsp_valid ? 1 : 0) + drop_count adjustment, i.e. every response not yet returned for pre-redirect requests is discarded; a response arriving in the redirect cycle itself is discarded.
REQ-026 Back-to-back redirects: last one wins; drop accounting per REQ-025 each cycle.
REQ-027 imem_rsp_valid with outstanding == 0 is a protocol error; assertion only, state unchanged.

Reset
REQ-028 On rst_n low (async): fetch_pc = rsp_pc = RESET_PC, queue_count = 0, outstanding = 0, drop_count = 0.
REQ-029 During reset: imem_req_valid = 0, instr_valid = 0, instr_data = 0, instr_pc = 0.
REQ-030 First request SHALL be issued the first cycle after rst_n deasserts, addr = RESET_PC.
REQ-031 Reset mid-operation discards all queued entries and in-flight responses; memory side is reset together.

Structure
REQ-032 Package fetch_pkg holds INSTR_BYTES = 4 and struct fetch_entry_t {pc, instr} parametrised by XLEN default.
REQ-033 Queue is sub-module fetch_fifo (DEPTH entries, fetch_entry_t, push/pop/flush, count output); all counters and PC logic stay in fetch_unit.

Verification
REQ-034 Reset release, memory 1-cycle latency, instr_ready=1 -> instr_pc sequence 0x0,0x4,0x8... one per cycle after fill.
REQ-035 instr_ready=0, DEPTH=4 -> exactly 4 requests (0x0..0xC) issued, then imem_req_valid=0 until a pop.
REQ-036 3 requests outstanding (latency 3), redirect_pc=0x100 -> 3 responses dropped, first instr_pc=0x100, no stale entry visible.
REQ-037 redirect_pc=0x103 -> imem_req_addr=0x100.
REQ-038 RESET_PC=0xFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-039 rst_n asserted with 2 entries queued and 2 outstanding -> instr_valid=0 immediately, restart at RESET_PC.
